// File: rtl/slavespi_pkg.sv
// slavespi_pkg: shared address defaults, counter width and status byte layout
package slavespi_pkg;
    localparam logic [3:0] DEF_CFG_PAGE  = 4'h5;
    localparam logic [7:0] DEF_FIFO_ADDR = 8'h70;
    localparam logic [7:0] DEF_STAT_ADDR = 8'h71;
    localparam int BCW = 6;
    typedef struct packed {
        logic       ovf;
        logic [6:0] level;
    } stat_t;
endpackage

// File: rtl/slavespi_if.sv
// slavespi_if: AVR SPI pins, config outputs and RX FIFO consumer port
interface slavespi_if #(parameter int NREG = 8, parameter int REG_BYTES = 2);
    logic                        spics_n, spick, spido, spidi;
    logic [7:0]                  status_in, fifo_dout;
    logic [NREG*REG_BYTES*8-1:0] cfg_out;
    logic [NREG-1:0]             cfg_stb;
    logic                        fifo_empty, fifo_rd, fifo_ovf;
    modport slave (input spics_n, spick, spido, status_in, fifo_rd,
                   output spidi, cfg_out, cfg_stb, fifo_dout, fifo_empty, fifo_ovf);
    modport master (output spics_n, spick, spido, status_in, fifo_rd,
                    input spidi, cfg_out, cfg_stb, fifo_dout, fifo_empty, fifo_ovf);
endinterface

// File: rtl/slavespi_gen_fifo.sv
// spi_byte_fifo: show-ahead byte FIFO; a pop frees room for a push in the same cycle
module spi_byte_fifo #(parameter int AW = 4) (
    input  logic          fclk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level
);
    logic [7:0]  r_mem [2**AW];
    logic [AW:0] r_wp, r_rp;
    logic        w_pop, w_push;
    assign level  = r_wp - r_rp;
    assign empty  = level == '0;
    assign full   = level[AW];
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);
    assign dout   = r_mem[r_rp[AW-1:0]];
    always_ff @(posedge fclk)
        if (w_push) r_mem[r_wp[AW-1:0]] <= din;
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
        end
    end
endmodule

// File: rtl/slavespi_gen.sv
// slavespi_gen: AVR SPI slave with multi-byte config registers, readback, status and an RX byte FIFO
module slavespi_gen
    import slavespi_pkg::*;
#(
    parameter int         NREG      = 8,
    parameter int         REG_BYTES = 2,
    parameter logic [3:0] CFG_PAGE  = DEF_CFG_PAGE,
    parameter logic [7:0] FIFO_ADDR = DEF_FIFO_ADDR,
    parameter logic [7:0] STAT_ADDR = DEF_STAT_ADDR,
    parameter int         FIFO_AW   = 4
) (
    input logic        fclk,
    input logic        rst_n,
    slavespi_if.slave  bus
);
    localparam int RW = REG_BYTES * 8;
    logic [2:0]         r_cs, r_ck, r_bit;
    logic [1:0]         r_do;
    logic [7:0]         r_regnum, r_shin, r_shout;
    logic [BCW-1:0]     r_bitcnt;
    logic [RW-1:0]      r_stage;
    logic [NREG*RW-1:0] r_cfg;
    logic [NREG-1:0]    r_stb;
    logic               r_ovf;
    logic               w_scs_01, w_scs_10, w_sck_01, w_data, w_byte_done, w_cfg_hit, w_push, w_full;
    logic [7:0]         w_byte, w_rb;
    logic [3:0]         w_ci;
    logic [FIFO_AW:0]   w_level;
    logic [6:0]         w_lvl7;
    stat_t              w_stat;
    int                 w_n;
    assign w_scs_01    = r_cs[1] & ~r_cs[2];
    assign w_scs_10    = ~r_cs[1] & r_cs[2];
    assign w_sck_01    = r_ck[1] & ~r_ck[2];
    assign w_data      = ~r_cs[1];
    assign w_byte      = {r_do[1], r_shin[7:1]};
    assign w_byte_done = w_sck_01 & w_data & (r_bit == 3'd7);
    assign w_cfg_hit   = (r_regnum[7:4] == CFG_PAGE) && (int'(r_regnum[3:0]) < NREG);
    assign w_ci        = w_cfg_hit ? r_regnum[3:0] : 4'd0;
    assign w_push      = w_byte_done & (r_regnum == FIFO_ADDR);
    assign w_lvl7      = (int'(w_level) > 127) ? 7'd127 : 7'(w_level);
    assign w_stat      = '{ovf: r_ovf, level: w_lvl7};
    // readback byte: byte 0 at data-phase start, otherwise the byte after the one just completed
    always_comb begin
        w_n  = w_scs_10 ? 0 : int'(r_bitcnt[5:3]) + 1;
        w_rb = (w_n < REG_BYTES) ? r_cfg[(int'(w_ci) * REG_BYTES + w_n) * 8 +: 8] : 8'h00;
    end
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs     <= 3'b111;
            r_ck     <= '0;
            r_do     <= '0;
            r_bit    <= '0;
            r_regnum <= '0;
            r_shin   <= '0;
            r_shout  <= '0;
            r_bitcnt <= '0;
            r_stage  <= '0;
            r_cfg    <= '0;
            r_stb    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_cs  <= {r_cs[1:0], bus.spics_n};
            r_ck  <= {r_ck[1:0], bus.spick};
            r_do  <= {r_do[0], bus.spido};
            r_stb <= '0;
            if (w_scs_01) r_regnum <= '0;
            else if (w_sck_01 && !w_data) r_regnum <= {r_do[1], r_regnum[7:1]};
            if (w_scs_10) begin
                r_bitcnt <= '0;
                r_bit    <= '0;
                r_stage  <= '0;
            end else if (w_sck_01 && w_data) begin
                r_shin <= w_byte;
                r_bit  <= r_bit + 3'd1;
                if (r_bitcnt != '1) r_bitcnt <= r_bitcnt + 1'b1;
                if (w_byte_done && w_cfg_hit && int'(r_bitcnt[5:3]) < REG_BYTES)
                    r_stage[int'(r_bitcnt[5:3]) * 8 +: 8] <= w_byte;
            end
            // commit only an exact-length write
            if (w_scs_01 && w_cfg_hit && int'(r_bitcnt) == RW) begin
                r_cfg[int'(w_ci) * RW +: RW] <= r_stage;
                r_stb <= NREG'(1) << w_ci;
            end
            if (w_scs_01) r_shout <= bus.status_in;
            else if (w_scs_10) r_shout <= w_cfg_hit ? w_rb : (r_regnum == STAT_ADDR ? w_stat : 8'h00);
            else if (w_byte_done) r_shout <= w_cfg_hit ? w_rb : 8'h00;
            else if (w_sck_01) r_shout <= {1'b0, r_shout[7:1]};
            if (w_push && w_full && !bus.fifo_rd) r_ovf <= 1'b1;
            else if (w_scs_01 && r_regnum == STAT_ADDR) r_ovf <= 1'b0;
        end
    end
    spi_byte_fifo #(.AW(FIFO_AW)) u_fifo (
        .fclk  (fclk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   (w_byte),
        .pop   (bus.fifo_rd),
        .dout  (bus.fifo_dout),
        .empty (bus.fifo_empty),
        .full  (w_full),
        .level (w_level)
    );
    assign bus.spidi    = r_shout[0];
    assign bus.cfg_out  = r_cfg;
    assign bus.cfg_stb  = r_stb;
    assign bus.fifo_ovf = r_ovf;
endmodule

// File: tb/tb_slavespi_gen.sv
// tb_slavespi_gen: directed SPI transactions with scoreboard queues for readback and FIFO contents
module tb_slavespi_gen;
    logic         fclk = 1'b0, rst_n = 1'b0;
    int           errors = 0, checks = 0, stb_cnt;
    logic [7:0]   stb_val, q, st;
    logic [127:0] stb_cfg;
    logic         mdl_ovf = 1'b0;
    logic [7:0]   fifo_q[$], rb_q[$];

    slavespi_if #(.NREG(8), .REG_BYTES(2)) bus();
    slavespi_gen dut (.fclk(fclk), .rst_n(rst_n), .bus(bus));
    always #5 fclk = ~fclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic spi_bit(input logic d, input logic pop, output logic miso);
        bus.spido = d;
        repeat (4) @(negedge fclk);
        miso = bus.spidi;
        bus.spick = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            @(negedge fclk);
            if (pop && j == 2) bus.fifo_rd = 1'b1;
            if (j == 3) bus.fifo_rd = 1'b0;
        end
        bus.spick = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] d, input logic pop_last, output logic [7:0] r);
        logic b;
        for (int i = 0; i < 8; i++) begin
            spi_bit(d[i], pop_last && i == 7, b);
            r[i] = b;
        end
    endtask

    task automatic cs_begin(input logic [7:0] rn, output logic [7:0] s);
        bus.spics_n = 1'b1;
        spi_byte(rn, 1'b0, s);
        @(negedge fclk);
        bus.spics_n = 1'b0;
        repeat (8) @(negedge fclk);
    endtask

    task automatic cs_end();
        repeat (4) @(negedge fclk);
        bus.spics_n = 1'b1;
        stb_cnt = 0;
        stb_val = '0;
        stb_cfg = '0;
        repeat (12) begin
            @(negedge fclk);
            if (bus.cfg_stb != '0) begin
                stb_cnt++;
                stb_val = bus.cfg_stb;
                stb_cfg = bus.cfg_out;
            end
        end
    endtask

    task automatic fifo_write(input logic [7:0] d);
        cs_begin(8'h70, st);
        spi_byte(d, 1'b0, q);
        cs_end();
        if (fifo_q.size() < 16) fifo_q.push_back(d);
        else mdl_ovf = 1'b1;
    endtask

    task automatic pop_chk(input string tag);
        chk({tag, "_nonempty"}, 64'(bus.fifo_empty), 64'(0));
        chk(tag, 64'(bus.fifo_dout), 64'(fifo_q.pop_front()));
        bus.fifo_rd = 1'b1;
        @(negedge fclk);
        bus.fifo_rd = 1'b0;
        @(negedge fclk);
    endtask

    initial begin
        bus.spics_n = 1'b1; bus.spick = 1'b0; bus.spido = 1'b0;
        bus.status_in = 8'hA5; bus.fifo_rd = 1'b0;
        repeat (3) @(negedge fclk);
        chk("rst_cfg", bus.cfg_out[63:0] | bus.cfg_out[127:64], 64'(0));
        chk("rst_stb", 64'(bus.cfg_stb), 64'(0));
        chk("rst_empty", 64'(bus.fifo_empty), 64'(1));
        chk("rst_ovf", 64'(bus.fifo_ovf), 64'(0));
        chk("rst_spidi", 64'(bus.spidi), 64'(0));
        rst_n = 1'b1;
        repeat (3) @(negedge fclk);

        cs_begin(8'h52, st); spi_byte(8'h34, 1'b0, q); spi_byte(8'h12, 1'b0, q); cs_end();
        chk("wr2_lo", bus.cfg_out[63:0], 64'h0000_1234_0000_0000);
        chk("wr2_hi", bus.cfg_out[127:64], 64'(0));
        chk("wr2_stb_cnt", 64'(stb_cnt), 64'(1));
        chk("wr2_stb", 64'(stb_val), 64'h04);
        chk("wr2_cfg_at_stb", 64'(stb_cfg[47:32]), 64'h1234);

        cs_begin(8'h52, st); spi_byte(8'hAA, 1'b0, q); cs_end();
        chk("short8_cfg", 64'(bus.cfg_out[47:32]), 64'h1234);
        chk("short8_stb", 64'(stb_cnt), 64'(0));
        cs_begin(8'h52, st);
        spi_byte(8'hAA, 1'b0, q); spi_byte(8'hBB, 1'b0, q); spi_byte(8'hCC, 1'b0, q);
        cs_end();
        chk("long24_cfg", 64'(bus.cfg_out[47:32]), 64'h1234);
        chk("long24_stb", 64'(stb_cnt), 64'(0));

        cs_begin(8'h52, st);
        chk("rb_status", 64'(st), 64'hA5);
        rb_q.push_back(8'h34); rb_q.push_back(8'h12); rb_q.push_back(8'h00);
        for (int i = 0; i < 3; i++) begin
            spi_byte(8'h00, 1'b0, q);
            chk("rb_byte", 64'(q), 64'(rb_q.pop_front()));
        end
        cs_end();
        chk("rb_nostb", 64'(stb_cnt), 64'(0));
        chk("rb_cfg_kept", 64'(bus.cfg_out[47:32]), 64'h1234);

        for (int i = 0; i < 17; i++) fifo_write(8'(i));
        chk("ff_nonempty", 64'(bus.fifo_empty), 64'(0));
        chk("ff_ovf", 64'(bus.fifo_ovf), 64'(mdl_ovf));
        cs_begin(8'h71, st);
        spi_byte(8'h00, 1'b0, q);
        chk("stat_full", 64'(q), 64'({mdl_ovf, 7'(fifo_q.size())}));
        chk("stat_full_const", 64'(q), 64'h90);
        cs_end();
        mdl_ovf = 1'b0;
        chk("ovf_cleared", 64'(bus.fifo_ovf), 64'(mdl_ovf));
        for (int i = 0; i < 16; i++) pop_chk("pop");
        chk("ff_drained", 64'(bus.fifo_empty), 64'(1));

        for (int i = 0; i < 16; i++) fifo_write(8'h40 + 8'(i));
        cs_begin(8'h70, st);
        spi_byte(8'h50, 1'b1, q);
        cs_end();
        void'(fifo_q.pop_front());
        fifo_q.push_back(8'h50);
        chk("sim_ovf", 64'(bus.fifo_ovf), 64'(0));
        chk("sim_head", 64'(bus.fifo_dout), 64'(fifo_q[0]));
        cs_begin(8'h71, st);
        spi_byte(8'h00, 1'b0, q);
        chk("sim_stat", 64'(q), 64'({1'b0, 7'(fifo_q.size())}));
        cs_end();
        for (int i = 0; i < 16; i++) pop_chk("sim_pop");
        chk("sim_drained", 64'(bus.fifo_empty), 64'(1));

        fifo_write(8'h77);
        chk("pre_rst_dout", 64'(bus.fifo_dout), 64'h77);
        cs_begin(8'h50, st);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b0, q[0]);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cfg", bus.cfg_out[63:0] | bus.cfg_out[127:64], 64'(0));
        chk("arst_stb", 64'(bus.cfg_stb), 64'(0));
        chk("arst_empty", 64'(bus.fifo_empty), 64'(1));
        chk("arst_ovf", 64'(bus.fifo_ovf), 64'(0));
        chk("arst_spidi", 64'(bus.spidi), 64'(0));
        fifo_q.delete();
        bus.spics_n = 1'b1; bus.spick = 1'b0;
        repeat (3) @(negedge fclk);
        rst_n = 1'b1;
        repeat (3) @(negedge fclk);
        cs_begin(8'h50, st); spi_byte(8'hFF, 1'b0, q); spi_byte(8'h01, 1'b0, q); cs_end();
        chk("post_rst_cfg", bus.cfg_out[63:0], 64'h0000_0000_0000_01FF);
        chk("post_rst_stb_cnt", 64'(stb_cnt), 64'(1));
        chk("post_rst_stb", 64'(stb_val), 64'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
